// File: rtl/fetch_unit.sv
// PC sequencer and fetch control for the 9-bit core.
// Owns the branch target table and the retired-instruction counter.
module fetch_unit #(
  parameter int              PC_W       = 10,
  parameter int              LUT_AW     = 3,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              start,
  input  logic              stall,
  input  logic [8:0]        Instruction,
  input  logic              branch_en,
  input  logic              lut_wr_en,
  input  logic [LUT_AW-1:0] lut_wr_addr,
  input  logic [PC_W-1:0]   lut_wr_data,
  output logic [PC_W-1:0]   PC,
  output logic              fetch_valid,
  output logic              done,
  output logic [15:0]       instr_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  localparam int LUT_N = 2 ** LUT_AW;

  state_t            state;
  logic [PC_W-1:0]   lut [LUT_N];
  logic [LUT_AW-1:0] br_idx;
  logic              is_halt;
  logic              take_br;
  logic              seq;
  logic              cnt_sat;

  assign br_idx      = Instruction[3 +: LUT_AW];
  assign is_halt     = (Instruction == 9'h1FF);
  assign take_br     = branch_en & ~is_halt;
  assign seq         = ~branch_en & ~is_halt;
  assign cnt_sat     = (instr_count == 16'hFFFF);
  assign fetch_valid = (state == RUN);

  // Branch reads see the pre-edge table, so a same-cycle write wins next time.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      PC          <= START_ADDR;
      done        <= 1'b0;
      instr_count <= '0;
      for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
    end else begin
      if (lut_wr_en) lut[lut_wr_addr] <= lut_wr_data;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            PC          <= START_ADDR;
            instr_count <= '0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (!cnt_sat) instr_count <= instr_count + 16'd1;
            unique case (1'b1)
              is_halt: begin
                state <= HALTED;
                done  <= 1'b1;
              end
              take_br: PC <= lut[br_idx];
              seq:     PC <= PC + PC_W'(1);
            endcase
          end
        end
        HALTED: begin
          if (start) begin
            state       <= RUN;
            done        <= 1'b0;
            PC          <= START_ADDR;
            instr_count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit.
// A cycle-level behavioural model predicts every output.
module tb_fetch_unit;

  localparam logic [8:0] HALT = 9'h1FF;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic [8:0] Instruction = '0;
  logic       branch_en = 1'b0;
  logic       lut_wr_en = 1'b0;
  logic [2:0] lut_wr_addr = '0;
  logic [9:0] lut_wr_data = '0;

  logic [9:0]  PC;
  logic        fetch_valid;
  logic        done;
  logic [15:0] instr_count;

  logic [9:0]  w_pc;
  logic        w_fv;
  logic        w_done;
  logic [15:0] w_cnt;

  fetch_unit u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .stall(stall),
    .Instruction(Instruction), .branch_en(branch_en),
    .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr),
    .lut_wr_data(lut_wr_data), .PC(PC), .fetch_valid(fetch_valid),
    .done(done), .instr_count(instr_count)
  );

  fetch_unit #(.START_ADDR(10'h3FE)) u_wrap (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .stall(stall),
    .Instruction(Instruction), .branch_en(branch_en),
    .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr),
    .lut_wr_data(lut_wr_data), .PC(w_pc), .fetch_valid(w_fv),
    .done(w_done), .instr_count(w_cnt)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  bit m_run;
  bit m_done;
  int m_pc;
  int m_cnt;
  int m_tab [8];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_done = 0;
    m_pc   = 0;
    m_cnt  = 0;
    for (int i = 0; i < 8; i++) m_tab[i] = 0;
  endtask

  // One clock of the programmer-visible behaviour.
  task automatic model_step();
    int tgt;
    tgt = m_tab[(int'(Instruction) >> 3) % 8];
    if (m_run) begin
      if (!stall) begin
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        if (Instruction == HALT) begin
          m_run  = 0;
          m_done = 1;
        end else if (branch_en) begin
          m_pc = tgt;
        end else begin
          m_pc = (m_pc + 1) % 1024;
        end
      end
    end else if (start) begin
      m_run  = 1;
      m_done = 0;
      m_pc   = 0;
      m_cnt  = 0;
    end
    if (lut_wr_en) m_tab[lut_wr_addr] = int'(lut_wr_data);
  endtask

  task automatic compare_all();
    chk("pc", PC, m_pc);
    chk("done", done, m_done);
    chk("fetch_valid", fetch_valid, m_run);
    chk("instr_count", instr_count, m_cnt);
  endtask

  task automatic step(input bit do_chk);
    @(posedge CLK);
    model_step();
    #1;
    if (do_chk) compare_all();
  endtask

  task automatic idle_inputs();
    start       = 0;
    stall       = 0;
    Instruction = '0;
    branch_en   = 0;
    lut_wr_en   = 0;
    lut_wr_addr = '0;
    lut_wr_data = '0;
  endtask

  task automatic run_to(input int tgt);
    Instruction = '0;
    branch_en   = 0;
    for (int k = 0; k < 1100 && m_pc != tgt; k++) step(1);
    chk("run_to", PC, tgt);
  endtask

  task automatic halt_and_start();
    Instruction = HALT;
    step(1);
    Instruction = '0;
    start = 1;
    step(1);
    start = 0;
  endtask

  // Called just after a rising edge; reset drops mid-cycle.
  task automatic do_reset();
    #3 RESET_N = 0;
    model_reset();
    #1;
    chk("rst_pc", PC, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", instr_count, 0);
    chk("rst_fv", fetch_valid, 0);
    #2 RESET_N = 1;
  endtask

  initial begin
    int c0;
    model_reset();
    idle_inputs();
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1;
    compare_all();
    step(1);

    // straight line, HALT at 5
    start = 1;
    step(1);
    start = 0;
    for (int k = 0; k < 20 && m_run; k++) begin
      if (k <= 5) chk("sl_seq", PC, k);
      Instruction = (m_pc == 5) ? HALT : 9'h000;
      step(1);
    end
    chk("sl_done", done, 1);
    chk("sl_cnt", instr_count, 6);
    chk("sl_fv", fetch_valid, 0);
    chk("sl_pc_hold", PC, 5);
    idle_inputs();

    // taken and not-taken branch
    lut_wr_en = 1; lut_wr_addr = 3'd2; lut_wr_data = 10'h040;
    step(1);
    lut_wr_en = 0;
    start = 1;
    step(1);
    start = 0;
    run_to(3);
    Instruction = 9'h010; branch_en = 1;
    step(1);
    chk("br_taken", PC, 10'h040);
    branch_en = 0;
    halt_and_start();
    run_to(3);
    Instruction = 9'h010; branch_en = 0;
    step(1);
    chk("br_not_taken", PC, 4);

    // stall with HALT on the bus
    run_to(7);
    c0 = m_cnt;
    Instruction = HALT; stall = 1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("stall_pc", PC, 7);
      chk("stall_cnt", instr_count, c0);
      chk("stall_nohalt", done, 0);
    end
    stall = 0; Instruction = '0;
    step(1);
    chk("stall_next", PC, 8);

    // write/read collision on entry 1
    lut_wr_en = 1; lut_wr_addr = 3'd1; lut_wr_data = 10'h020;
    step(1);
    Instruction = 9'h008; branch_en = 1; lut_wr_data = 10'h100;
    step(1);
    chk("coll_old", PC, 10'h020);
    lut_wr_en = 0;
    step(1);
    chk("coll_new", PC, 10'h100);
    idle_inputs();

    // async reset mid-run, then restart from HALTED
    halt_and_start();
    run_to(9);
    do_reset();
    start = 1;
    step(1);
    start = 0;
    step(1);
    Instruction = HALT;
    step(1);
    chk("rs_done", done, 1);
    Instruction = '0; start = 1;
    step(1);
    start = 0;
    chk("rs_cleared", done, 0);
    chk("rs_pc", PC, 0);

    // PC wrap on the 3FE-start instance
    do_reset();
    chk("wrap_idle", w_pc, 10'h3FE);
    start = 1;
    step(1);
    start = 0;
    chk("wrap_0", w_pc, 10'h3FE);
    step(1);
    chk("wrap_1", w_pc, 10'h3FF);
    step(1);
    chk("wrap_2", w_pc, 10'h000);
    chk("wrap_cnt", w_cnt, 2);

    // counter saturation with a branch-to-self loop
    do_reset();
    start = 1;
    step(1);
    start = 0;
    lut_wr_en = 1; lut_wr_addr = 3'd0; lut_wr_data = 10'd5;
    step(1);
    lut_wr_en = 0;
    Instruction = 9'h000; branch_en = 1;
    for (int k = 0; k < 70000; k++) step(k % 8192 == 0);
    compare_all();
    chk("sat_cnt", instr_count, 16'hFFFF);
    chk("sat_pc", PC, 5);
    idle_inputs();

    // random traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      start       = ($urandom_range(0, 9) == 0);
      stall       = ($urandom_range(0, 4) == 0);
      branch_en   = ($urandom_range(0, 3) == 0);
      Instruction = ($urandom_range(0, 29) == 0) ? HALT :
                    (9'($urandom) & 9'h1FE);
      lut_wr_en   = ($urandom_range(0, 3) == 0);
      lut_wr_addr = 3'($urandom);
      lut_wr_data = 10'($urandom);
      step(1);
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and instruction-fetch sequencer for the 9-bit core, sitting on the opposite side of the control decoder's branch interface. It drives the instruction ROM address and consumes the decoder's combinational `branch_en` to choose the next PC. Branch targets come from a small loadable target table. It also provides the start/done program handshake and a retired-instruction count.

## Interface
Parameters:
- `PC_W`, 10, PC and ROM address width
- `LUT_AW`, 3, target-table address width (2^LUT_AW entries)
- `START_ADDR`, 0, PC value at reset and at program start

Ports:
- `CLK`  in  1  clock, all state updates on rising edge
- `RESET_N`  in  1  reset, asynchronous and active-low
- `start`  in  1  one-cycle program start request
- `stall`  in  1  freeze fetch this cycle (data-memory wait)
- `Instruction`  in  9  ROM output for the current `PC`, combinational same cycle
- `branch_en`  in  1  from control decoder, combinational on the current `Instruction`
- `lut_wr_en`  in  1  target-table write strobe
- `lut_wr_addr`  in  LUT_AW  target-table write index
- `lut_wr_data`  in  PC_W  target-table write value (absolute PC)
- `PC`  out  PC_W  instruction ROM address, registered
- `fetch_valid`  out  1  `Instruction` is live and being executed this cycle
- `done`  out  1  program halted, registered
- `instr_count`  out  16  retired instructions since last start, registered

## Operation
- States: IDLE, RUN, HALTED. Reset puts the block in IDLE.
- Reset values: `PC`=START_ADDR, `done`=0, `instr_count`=0, all table entries=0.
- `fetch_valid` = (state==RUN). It is a decode of the registered state.
- A cycle retires when RUN is active and `stall`=0.
- IDLE: `PC` holds START_ADDR. `start`=1 → RUN with `PC`=START_ADDR and `instr_count`=0.
- RUN, `stall`=1: `PC`, `instr_count` and state hold. `branch_en` and HALT are ignored.
- RUN, retiring, next-PC priority:
  1. `Instruction`==9'h1FF (HALT) → HALTED, `done`=1, `PC` holds.
  2. `branch_en`=1 → `PC` = table[`Instruction[5:3]`] (low LUT_AW bits of that field).
  3. Otherwise `PC` = `PC`+1 modulo 2^PC_W, so 2^PC_W−1 wraps to 0.
- `instr_count` increments on every retiring cycle, HALT included. It saturates at 16'hFFFF and does not wrap.
- HALTED: `PC`, `instr_count` and `done` hold. `start`=1 → RUN with `done`=0, `PC`=START_ADDR and `instr_count`=0.
- `start` during RUN is ignored. `branch_en` outside RUN is ignored.
- Target table: write when `lut_wr_en`=1, in any state.
  - A write and a branch read of the same entry in the same cycle: the branch uses the old value and the write lands.
- `RESET_N` asserted mid-RUN: immediate return to reset values and IDLE. In-flight branch or count updates are lost.

## Timing
- `start` sampled at edge N → at N+1: state RUN, `fetch_valid`=1, `PC`=START_ADDR.
- Fetch latency 0: ROM and decoder are combinational on the registered `PC`, so the next PC is decided in the same cycle. One instruction retires per non-stalled cycle.
- A taken branch at edge k puts the target on `PC` after edge k. There is no delay slot and no bubble.
- HALT retiring at edge k: `done`=1 and `fetch_valid`=0 after edge k. `instr_count` includes the HALT.
- A stall asserted for S cycles delays every subsequent PC update by exactly S cycles.
- Target-table writes are visible to branches from the cycle after the write edge.

## Test plan
- Reset, start, straight-line: no branches, HALT at address 5 → `PC` sequence 0,1,2,3,4,5; `done`=1 after that edge; `instr_count`=6; `fetch_valid` falls with `done`.
- Taken branch: table[2]=10'h040, then `branch_en`=1 with `Instruction[5:3]`=2 at `PC`=3 → next `PC`=10'h040, no bubble. Same instruction with `branch_en`=0 → `PC`=4.
- Stall: 3-cycle `stall` at `PC`=7 → `PC` holds 7 for 3 cycles then advances to 8; `instr_count` unchanged across the stall; HALT under stall is not taken.
- Wrap and saturation: `START_ADDR`=10'h3FE with no branches → `PC` 3FE, 3FF, 000. A 70000-instruction loop via branch → `instr_count` sticks at 16'hFFFF.
- Write/read collision: write table[1]=10'h100 in the same cycle as a branch via index 1 holding 10'h020 → jumps to 10'h020. The next branch via index 1 → 10'h100.
- Async reset mid-RUN, then restart: drop `RESET_N` between edges while `PC`=9 → `PC`=START_ADDR, `done`=0, `instr_count`=0 immediately. Restart from HALTED via `start` clears `done` at the next edge.
